cosim_tick_scheduler: RTL and testbench

//   Paces the per-clock co-simulation time ticks issued from HDL to the SystemC kernel.
//   It replaces the free-running "tick every posedge after reset" call with a scheduler

---
 rtl/cosim_tick_scheduler.sv | 131 +++++++++++++
 tb/tb_cosim_tick_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_tick_scheduler.sv
// Paces HDL-to-SystemC co-simulation ticks: start/stop/single-step, programmable gap,
// tick budget and a stall watchdog around each req/ack handshake.
module cosim_tick_scheduler #(
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned COUNT_W  = 32,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                step,
    input  logic [PERIOD_W-1:0] period,
    input  logic [COUNT_W-1:0]  num_ticks,
    output logic                tick_req,
    input  logic                tick_ack,
    output logic [COUNT_W-1:0]  tick_count,
    output logic                busy,
    output logic                done,
    output logic                timeout_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StGap, StReq, StDone} state_e;

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0]   budget_q, budget_d;
    logic [PERIOD_W-1:0]  gap_q, gap_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 last_q, last_d;
    logic                 timeout_q, timeout_d;
    logic [COUNT_W-1:0]   count_inc;

    assign count_inc = count_q + COUNT_W'(1);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        budget_d  = budget_q;
        gap_d     = gap_q;
        wd_d      = wd_q;
        last_d    = last_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle, StDone: begin
                // stop outranks start/step; step is only honoured from idle
                if (!stop) begin
                    if (start) begin
                        state_d   = StReq;
                        count_d   = '0;
                        budget_d  = num_ticks;
                        timeout_d = 1'b0;
                        last_d    = 1'b0;
                        wd_d      = '0;
                    end else if (step && state_q == StIdle) begin
                        state_d = StReq;
                        last_d  = 1'b1;
                        wd_d    = '0;
                    end
                end
            end
            StGap: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (gap_q == '0) begin
                    state_d = StReq;
                    wd_d    = '0;
                end else begin
                    gap_d = gap_q - PERIOD_W'(1);
                end
            end
            StReq: begin
                // a stop never retracts the request; it only makes this tick the last
                if (stop) begin
                    last_d = 1'b1;
                end
                if (tick_ack) begin
                    count_d = count_inc;
                    wd_d    = '0;
                    if (budget_q != '0 && count_inc == budget_q) begin
                        state_d = StDone;
                    end else if (last_q || stop) begin
                        state_d = StIdle;
                    end else if (period > PERIOD_W'(1)) begin
                        state_d = StGap;
                        gap_d   = period - PERIOD_W'(2);
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            budget_q  <= '0;
            gap_q     <= '0;
            wd_q      <= '0;
            last_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            budget_q  <= budget_d;
            gap_q     <= gap_d;
            wd_q      <= wd_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        tick_req    = (state_q == StReq);
        busy        = (state_q == StReq) || (state_q == StGap);
        done        = (state_q == StDone);
        tick_count  = count_q;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_cosim_tick_scheduler.sv
// Bench for cosim_tick_scheduler: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cosim_tick_scheduler;

    localparam int unsigned PW = 8;
    localparam int unsigned CW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          step = 1'b0;
    logic [PW-1:0] period = '0;
    logic [CW-1:0] num_ticks = '0;
    logic          tick_req;
    logic          tick_ack = 1'b0;
    logic [CW-1:0] tick_count;
    logic          busy;
    logic          done;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_mode = 0;  // 0: never ack, 1: ack follows req, 2: ack tied high

    cosim_tick_scheduler #(
        .PERIOD_W (PW),
        .COUNT_W  (CW),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .period      (period),
        .num_ticks   (num_ticks),
        .tick_req    (tick_req),
        .tick_ack    (tick_ack),
        .tick_count  (tick_count),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial forever #5 clk = ~clk;

    // Bridge model
    initial forever begin
        @(negedge clk);
        case (ack_mode)
            0:       tick_ack = 1'b0;
            1:       tick_ack = tick_req;
            default: tick_ack = 1'b1;
        endcase
    end

    // Reference model: mode 0 idle, 1 running, 2 done; the gap is an absolute rise time
    int          m_mode = 0;
    bit          m_req = 1'b0;
    bit          m_single = 1'b0;
    bit          m_err = 1'b0;
    int          m_wait = 0;
    longint      m_next = 0;
    longint      cyc = 0;
    logic [CW-1:0] m_count = '0;
    logic [CW-1:0] m_budget = '0;

    task automatic model_reset();
        m_mode = 0; m_req = 1'b0; m_single = 1'b0; m_err = 1'b0;
        m_wait = 0; m_count = '0; m_budget = '0;
    endtask

    task automatic model_step();
        int p;
        p = (period == '0) ? 1 : int'(period);
        cyc++;
        if (m_mode != 1) begin
            if (!stop && start) begin
                m_mode = 1; m_req = 1'b1; m_count = '0; m_err = 1'b0;
                m_budget = num_ticks; m_single = 1'b0; m_wait = 0;
            end else if (!stop && step && m_mode == 0) begin
                m_mode = 1; m_req = 1'b1; m_single = 1'b1; m_wait = 0;
            end
        end else if (!m_req) begin
            if (stop) m_mode = 0;
            else if (cyc == m_next) begin m_req = 1'b1; m_wait = 0; end
        end else begin
            if (stop) m_single = 1'b1;
            if (tick_ack) begin
                m_count = m_count + 1;
                m_wait = 0;
                if (m_budget != 0 && m_count == m_budget) begin
                    m_mode = 2; m_req = 1'b0;
                end else if (m_single) begin
                    m_mode = 0; m_req = 1'b0;
                end else if (p > 1) begin
                    m_req = 1'b0; m_next = cyc + p - 1;
                end
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_err = 1'b1; m_mode = 0; m_req = 1'b0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        n_tests++;
        if (tick_req !== (m_req && m_mode == 1) || busy !== (m_mode == 1) ||
            done !== (m_mode == 2) || timeout_err !== m_err || tick_count !== m_count) begin
            n_fail++;
            $display("FAIL model t=%0t got req=%b busy=%b done=%b err=%b cnt=%0d want req=%b busy=%b done=%b err=%b cnt=%0d",
                     $time, tick_req, busy, done, timeout_err, tick_count,
                     (m_req && m_mode == 1), (m_mode == 1), (m_mode == 2), m_err, m_count);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Called at a negedge; the pulse is sampled at the following posedge
    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask
    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask
    task automatic pulse_step();
        step = 1'b1; @(negedge clk); step = 1'b0;
    endtask

    initial begin
        logic [11:0] seen;
        int hi;
        // 1. reset
        repeat (5) @(negedge clk);
        check("reset_req", 32'(tick_req), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_count", tick_count, 0);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_no_req", 32'(tick_req), 0);
        end

        // 2. period 4, budget 3, ack one cycle after req
        ack_mode = 1; period = 8'd4; num_ticks = 32'd3;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            seen[11-i] = tick_req;
            @(negedge clk);
        end
        check("gap_pattern", 32'(seen), 32'(12'b1000_1000_1000));
        check("budget_done", 32'(done), 1);
        check("budget_count", tick_count, 3);
        check("budget_busy", 32'(busy), 0);
        pulse_step();
        @(negedge clk);
        check("step_in_done_busy", 32'(busy), 0);
        check("step_in_done_count", tick_count, 3);

        // 3. back-to-back with ack tied high, then stop
        ack_mode = 2; period = 8'd0; num_ticks = 32'd0;
        pulse_start();
        repeat (5) @(negedge clk);
        check("b2b_count", tick_count, 5);
        check("b2b_req", 32'(tick_req), 1);
        pulse_stop();
        check("stop_req_count", tick_count, 6);
        check("stop_req_idle", 32'(busy), 0);
        check("stop_req_low", 32'(tick_req), 0);

        // 4. single steps from idle: 6 -> 7 -> 8 -> 9
        ack_mode = 1;
        for (int i = 0; i < 3; i++) begin
            pulse_step();
            check("step_req", 32'(tick_req), 1);
            @(negedge clk);
            check("step_count", tick_count, 32'(7 + i));
            check("step_idle", 32'(busy), 0);
        end

        // stop during a gap returns to idle at once
        period = 8'd5;
        pulse_start();
        @(negedge clk);
        pulse_stop();
        check("gap_stop_busy", 32'(busy), 0);
        check("gap_stop_count", tick_count, 1);
        repeat (6) @(negedge clk);
        check("gap_stop_no_req", 32'(tick_req), 0);

        // 5. watchdog
        ack_mode = 0; period = 8'd2;
        pulse_start();
        hi = 0;
        while (tick_req && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        check("timeout_len", 32'(hi), 16);
        check("timeout_err", 32'(timeout_err), 1);
        check("timeout_busy", 32'(busy), 0);
        pulse_step();
        repeat (20) @(negedge clk);
        check("timeout_sticky", 32'(timeout_err), 1);
        ack_mode = 1; num_ticks = 32'd1;
        pulse_start();
        check("timeout_cleared", 32'(timeout_err), 0);
        @(negedge clk);
        check("one_tick_done", 32'(done), 1);
        check("one_tick_count", tick_count, 1);

        // 6. start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (3) begin
            check("start_stop_no_req", 32'(tick_req), 0);
            @(negedge clk);
        end
        check("start_stop_done", 32'(done), 1);

        // reset while a request is outstanding
        ack_mode = 0; num_ticks = 32'd0; period = 8'd1;
        pulse_start();
        check("pre_reset_req", 32'(tick_req), 1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_req", 32'(tick_req), 0);
        check("async_reset_count", tick_count, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_no_req", 32'(tick_req), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of run, want finish before 200000");
        $fatal(1);
    end

endmodule
